// File: rtl/ordena_pkg.sv
// Shared types and helpers for the sequential odd-even transposition sorter.
package ordena_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Pass counter must hold 0..n-1 and is never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ordena_cas.sv
// Combinational compare-swap cell: a is the lower-index element, b the higher one.
module ordena_cas #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         dir,
    output logic [W-1:0] lo_out,
    output logic [W-1:0] hi_out,
    output logic         swapped
);

    // dir = 0 keeps the smaller value low; ties never swap in either direction.
    assign swapped = dir ? (a < b) : (a > b);
    assign lo_out  = swapped ? b : a;
    assign hi_out  = swapped ? a : b;

endmodule

// File: rtl/ordena_n_seq.sv
// N-element W-bit sorter: one odd-even transposition pass per clock, valid/ready on both sides,
// with a bypass mode that returns the accepted vector unchanged.
module ordena_n_seq
    import ordena_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           ena,
    input  logic           cresc_ou_decres,
    input  logic [N*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data
);

    localparam int CW = cnt_width(N);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ena_q;
    logic          dir_q;
    logic [W-1:0]  elem     [N];
    logic [W-1:0]  elem_nxt [N];
    logic [W-1:0]  lo       [N-1];
    logic [W-1:0]  hi       [N-1];
    logic [N-2:0]  swapped;

    for (genvar k = 0; k < N - 1; k++) begin : g_cas
        ordena_cas #(.W(W)) u_cas (
            .a       (elem[k]),
            .b       (elem[k+1]),
            .dir     (dir_q),
            .lo_out  (lo[k]),
            .hi_out  (hi[k]),
            .swapped (swapped[k])
        );
    end

    // Even passes write back cells (0,1),(2,3)..., odd passes (1,2),(3,4)...; active cells are disjoint.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        elem_nxt = elem;
        for (int i = 0; i < N - 1; i++) begin
            if ((i % 2 == int'(cnt[0])) && swapped[i]) begin
                elem_nxt[i]   = lo[i];
                elem_nxt[i+1] = hi[i];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++) out_data[i*W +: W] = elem[i];
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state <= IDLE;
            cnt   <= '0;
            ena_q <= 1'b0;
            dir_q <= 1'b0;
            // NOTE: the element array is real flops feeding out_data, so it must be reset, not left as RAM.
            for (int i = 0; i < N; i++) elem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) elem[i] <= in_data[i*W +: W];
                        ena_q <= ena;
                        dir_q <= cresc_ou_decres;
                        cnt   <= '0;
                        state <= ena ? SORT : DONE;
                    end
                end
                SORT: begin
                    if (ena_q) elem <= elem_nxt;
                    if (cnt == CW'(N - 1)) state <= DONE;
                    else                   cnt   <= cnt + CW'(1);
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
